// File: rtl/soc_io_uart.sv
// Memory-mapped I/O block: an LED register plus a transmit-only 8N1 UART
// fed by a small TX FIFO, all on a single clock with synchronous reset.
module soc_io_uart #(
  parameter int LED_W      = 5,
  parameter int BAUD_DIV   = 234,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [3:0]       io_addr,
  input  logic [31:0]      io_wdata,
  input  logic             io_wr,
  input  logic             io_rd,
  output logic [31:0]      io_rdata,
  output logic [LED_W-1:0] LEDS,
  output logic             TXD
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BAUD_DIV - 1);
  localparam logic [PTR_W:0]   FIFO_FULLC = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] SEL_LED    = 2'd0;
  localparam logic [1:0] SEL_DATA   = 2'd1;
  localparam logic [1:0] SEL_STATUS = 2'd2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  typedef struct packed {
    tx_state_t      state;
    logic [2:0]     bit_idx;
    logic [PTR_W:0] count;
    logic           overflow;
  } tx_dbg_t;

  // Bus: io_wr/io_rd are one-cycle strobes with no backpressure; every access
  // completes on the edge it is sampled, and read data appears in io_rdata
  // on the following cycle and holds until the next read.
  logic [1:0] sel;
  assign sel = io_addr[3:2];

  logic [LED_W-1:0] leds_q;
  logic [31:0]      rdata_q;
  logic             overflow;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_head;

  tx_state_t      state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           txd_q;
  logic           bit_end;
  logic           tx_busy;

  logic push_req;
  logic push;
  logic pop;
  logic ovf_evt;

  tx_dbg_t dbg;

  assign fifo_full  = (fifo_count == FIFO_FULLC);
  assign fifo_empty = (fifo_count == '0);
  assign fifo_head  = mem[rd_ptr];
  assign bit_end    = (baud_cnt == BIT_LAST);
  assign tx_busy    = (state != IDLE) || !fifo_empty;

  // A pop frees a slot on the same edge, so a push into a full FIFO that
  // coincides with a pop is accepted rather than counted as overflow.
  assign pop      = !fifo_empty && ((state == IDLE) || (state == STOP && bit_end));
  assign push_req = io_wr && (sel == SEL_DATA);
  assign push     = push_req && (!fifo_full || pop);
  assign ovf_evt  = push_req && fifo_full && !pop;

  assign dbg = '{state, bit_idx, fifo_count, overflow};

  logic unused_ok;
  assign unused_ok = &{1'b0, io_addr[1:0], io_wdata, dbg};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= io_wdata[7:0];
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // TXD is registered from the current state, so the line lags the FSM by
  // one cycle; that lag is uniform, keeping back-to-back frames gap-free.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      txd_q    <= 1'b1;
    end else begin
      case (state)
        START:   txd_q <= 1'b0;
        DATA:    txd_q <= shreg[0];
        default: txd_q <= 1'b1;
      endcase
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            shreg    <= fifo_head;
            baud_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shreg    <= {1'b0, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (!fifo_empty) begin
              shreg <= fifo_head;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (sel)
      SEL_LED:    rd_mux = 32'(leds_q);
      SEL_STATUS: rd_mux = {23'd0, 5'(fifo_count), overflow, fifo_empty, fifo_full, tx_busy};
      default:    rd_mux = '0;
    endcase
  end

  // Status reads report pre-clear values; a same-edge overflow wins the clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      leds_q   <= '0;
      rdata_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (io_wr && sel == SEL_LED) begin
        leds_q <= io_wdata[LED_W-1:0];
      end
      if (io_rd) begin
        rdata_q <= rd_mux;
      end
      if (ovf_evt) begin
        overflow <= 1'b1;
      end else if (io_rd && sel == SEL_STATUS) begin
        overflow <= 1'b0;
      end
    end
  end

  assign io_rdata = rdata_q;
  assign LEDS     = leds_q;
  assign TXD      = txd_q;

endmodule

// File: tb/tb_soc_io_uart.sv
// Directed bench for soc_io_uart: register-access vector table plus
// hand-written sequences for UART framing, FIFO overflow and mid-frame reset.
module tb_soc_io_uart;

  localparam int LED_W      = 5;
  localparam int BAUD_DIV   = 4;
  localparam int FIFO_DEPTH = 4;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [3:0]       io_addr;
  logic [31:0]      io_wdata;
  logic             io_wr;
  logic             io_rd;
  logic [31:0]      io_rdata;
  logic [LED_W-1:0] leds;
  logic             TXD;

  soc_io_uart #(
    .LED_W      (LED_W),
    .BAUD_DIV   (BAUD_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_wr    (io_wr),
    .io_rd    (io_rd),
    .io_rdata (io_rdata),
    .LEDS     (leds),
    .TXD      (TXD)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        wr;
    logic        rd;
    logic [31:0] exp_rdata;
    logic [4:0]  exp_leds;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the active edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    io_addr  = a;
    io_wdata = d;
    io_wr    = 1'b1;
    tick();
    io_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    io_addr = a;
    io_rd   = 1'b1;
    tick();
    io_rd = 1'b0;
    d     = io_rdata;
  endtask

  // Expected line levels for one 8N1 frame at 4 cycles per bit, index 0 first.
  function automatic logic [39:0] frame_bits(input logic [7:0] b);
    logic [39:0] v;
    for (int i = 0; i < 40; i++) begin
      if (i < 4)       v[i] = 1'b0;
      else if (i < 36) v[i] = b[(i - 4) / 4];
      else             v[i] = 1'b1;
    end
    return v;
  endfunction

  // Scoreboard: capture 40 line samples and compare with the next queued byte.
  task automatic check_frame(input string name);
    logic [39:0] act;
    logic [7:0]  b;
    b = 8'h00;
    for (int i = 0; i < 40; i++) begin
      tick();
      act[i] = TXD;
    end
    if (exp_q.size() > 0) begin
      b = exp_q.pop_front();
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no expected byte queued, got frame 0x%0h", name, act);
    end
    check(name, 64'(act), 64'(frame_bits(b)));
  endtask

  task automatic watch_idle(input string name, input int cycles);
    logic seen_low;
    seen_low = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (TXD !== 1'b1) seen_low = 1'b1;
    end
    check(name, 64'(seen_low), 64'h0);
  endtask

  logic [31:0] rd_val;
  logic [31:0] rd_b2b;
  logic [39:0] exp_frame;
  logic [14:0] act_prefix;

  initial begin
    vecs[0]  = '{4'h0, 32'hFFFF_FFE5, 1'b1, 1'b0, 32'h0000_0004, 5'h05};
    vecs[1]  = '{4'h0, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0005, 5'h05};
    vecs[2]  = '{4'h4, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 5'h05};
    vecs[3]  = '{4'hC, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0000, 5'h05};
    vecs[4]  = '{4'hC, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 5'h05};
    vecs[5]  = '{4'h0, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_0000, 5'h03};
    vecs[6]  = '{4'h0, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0003, 5'h03};
    vecs[7]  = '{4'h8, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0004, 5'h03};
    vecs[8]  = '{4'h0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0004, 5'h03};
    vecs[9]  = '{4'h8, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0004, 5'h03};
    vecs[10] = '{4'h8, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0004, 5'h03};
    vecs[11] = '{4'h0, 32'h0000_001C, 1'b1, 1'b1, 32'h0000_0003, 5'h1C};
    vecs[12] = '{4'h0, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_001C, 5'h1C};
    vecs[13] = '{4'h3, 32'h0000_000A, 1'b1, 1'b0, 32'h0000_001C, 5'h0A};
    vecs[14] = '{4'h9, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0004, 5'h0A};

    RESET    = 1'b1;
    io_addr  = '0;
    io_wdata = '0;
    io_wr    = 1'b0;
    io_rd    = 1'b0;
    repeat (3) tick();
    RESET = 1'b0;
    check("reset leds", 64'(leds), 64'h0);
    check("reset txd", 64'(TXD), 64'h1);
    check("reset rdata", 64'(io_rdata), 64'h0);
    bus_read(4'h8, rd_val);
    check("reset status", 64'(rd_val), 64'h004);

    // Register-access table
    for (int i = 0; i < 15; i++) begin
      io_addr  = vecs[i].addr;
      io_wdata = vecs[i].wdata;
      io_wr    = vecs[i].wr;
      io_rd    = vecs[i].rd;
      tick();
      io_wr = 1'b0;
      io_rd = 1'b0;
      check($sformatf("vec%0d rdata", i), 64'(io_rdata), 64'(vecs[i].exp_rdata));
      check($sformatf("vec%0d leds", i), 64'(leds), 64'(vecs[i].exp_leds));
      check($sformatf("vec%0d txd", i), 64'(TXD), 64'h1);
    end

    // Single frame 0xA5: start bit begins two cycles after the write edge
    bus_write(4'h4, 32'h0000_00A5);
    exp_q.push_back(8'hA5);
    check("a5 txd write+0", 64'(TXD), 64'h1);
    tick();
    check("a5 txd write+1", 64'(TXD), 64'h1);
    check_frame("a5 frame");
    tick();
    check("a5 txd after frame", 64'(TXD), 64'h1);
    bus_read(4'h8, rd_val);
    check("a5 status idle", 64'(rd_val), 64'h004);

    // Six back-to-back pushes: one popped, four queued, sixth dropped
    for (int n = 0; n < 5; n++) exp_q.push_back(8'(8'h11 + n));
    fork
      begin
        for (int n = 0; n < 6; n++) bus_write(4'h4, 32'h11 + 32'(n));
        bus_read(4'h8, rd_b2b);
        check("b2b status overflow", 64'(rd_b2b), 64'h4B);
        bus_read(4'h8, rd_b2b);
        check("b2b status cleared", 64'(rd_b2b), 64'h43);
      end
      begin
        tick();
        tick();
        check("b2b txd write+1", 64'(TXD), 64'h1);
        for (int n = 0; n < 5; n++) check_frame($sformatf("b2b frame %0d", n));
      end
    join
    watch_idle("b2b no sixth frame", 44);
    bus_read(4'h8, rd_val);
    check("b2b status idle", 64'(rd_val), 64'h004);
    check("b2b queue drained", 64'(exp_q.size()), 64'h0);

    // Reset during frame cycle 15, with a second byte still queued
    bus_write(4'h4, 32'h0000_005A);
    bus_write(4'h4, 32'h0000_007E);
    exp_frame = frame_bits(8'h5A);
    for (int i = 0; i < 15; i++) begin
      tick();
      act_prefix[i] = TXD;
    end
    check("rst frame prefix", 64'(act_prefix), 64'(exp_frame[14:0]));
    RESET    = 1'b1;
    io_addr  = 4'h4;
    io_wdata = 32'h0000_0055;
    io_wr    = 1'b1;
    tick();
    io_wr = 1'b0;
    check("rst txd next cycle", 64'(TXD), 64'h1);
    io_addr = 4'h0;
    io_rd   = 1'b1;
    tick();
    io_rd = 1'b0;
    RESET = 1'b0;
    check("rst rdata", 64'(io_rdata), 64'h0);
    check("rst leds", 64'(leds), 64'h0);
    check("rst txd", 64'(TXD), 64'h1);
    bus_read(4'h8, rd_val);
    check("rst status", 64'(rd_val), 64'h004);
    watch_idle("rst no further frames", 60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
